mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Arbiter that shares the single external memory bus between the instruction-fetch port and the MEM-stage data port of the five-stage pipeline. It sequences each access through a request/acknowledge handshake with the bus slave, returns read data to the winning requester, and raises `stall_req` to pipeline control while any port is waiting. Data accesses have priority, with a burst limit that prevents instruction-fetch starvation.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_D_BURST`, 4, maximum consecutive data grants while a fetch is pending
- `TIMEOUT`, 255, bus watchdog limit in cycles (used only with the macro)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_ack`  out  1  one-cycle completion pulse
- `i_rdata`  out  DATA_W  fetch data, valid while `i_ack`=1
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = write
- `d_sel`  in  4  byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_ack`  out  1  one-cycle completion pulse
- `d_rdata`  out  DATA_W  read data, valid while `d_ack`=1
- `bus_req`  out  1  bus cycle active
- `bus_we`  out  1  write strobe
- `bus_sel`  out  4  byte enables (4'b1111 for fetch)
- `bus_addr`  out  ADDR_W  address
- `bus_wdata`  out  DATA_W  write data
- `bus_ack`  in  1  slave completion
- `bus_rdata`  in  DATA_W  slave read data, valid with `bus_ack`
- `bus_err`  out  1  one-cycle watchdog abort pulse (tied 0 without macro)
- `stall_req`  out  1  to pipeline control

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE grant rule: D wins if `d_req` and (`!i_req` or `burst_cnt` < MAX_D_BURST); otherwise I wins if `i_req`; otherwise stay IDLE.
- On grant: register addr/we/sel/wdata into bus outputs, set `bus_req`=1, go BUSY_x. Fetch grants drive `bus_we`=0 and `bus_sel`=4'b1111.
- BUSY_x: bus outputs held stable. On `bus_ack`: clear `bus_req`, capture `bus_rdata` into x_rdata, go RESP with x_ack=1.
- RESP: exactly one ack pulse, then IDLE. `bus_ack` is ignored in IDLE and RESP.
- `burst_cnt` (width clog2(MAX_D_BURST+1)):
  - +1 on a D grant while `i_req`=1.
  - Cleared on an I grant, or on a D grant with `i_req`=0.
  - Saturates at MAX_D_BURST.
- x_rdata retains its last value outside its ack cycle. Write accesses return `bus_rdata` unchanged; the requester ignores it.
- Protocol rule: a requester must not drop its req before its ack. If it does, the arbiter still completes the access and pulses the ack.
- `stall_req` = (`i_req` & !`i_ack`) | (`d_req` & !`d_ack`), combinational from registered acks.
- Reset values: all outputs 0, FSM in IDLE, `burst_cnt`=0. Reset mid-access drops `bus_req` asynchronously, and a late `bus_ack` from the slave is ignored.

## Timing
- Grant decision in cycle 0 (IDLE); `bus_req`=1 from cycle 1.
- Slave acks in cycle k ≥ 1 → x_ack and x_rdata valid in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-ack latency: 2 cycles. Back-to-back accesses issue one every 3 cycles minimum.
- Simultaneous `i_req` and `d_req` in IDLE: resolved by the grant rule in the same cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A watchdog counts cycles in BUSY_x and clears on leaving BUSY_x.
  - When it reaches TIMEOUT with no `bus_ack`: drop `bus_req`, go RESP, pulse x_ack with x_rdata=0, and pulse `bus_err` in the same cycle.
- Undefined: no watchdog, `bus_err` tied 0, BUSY_x waits indefinitely.

## Structure
- Shared package `arb_pkg`: FSM state encoding (IDLE/BUSY_I/BUSY_D/RESP), default ADDR_W/DATA_W, and the `SEL_ALL` = 4'b1111 constant.
- One sub-module `arb_watchdog` (counter + compare, start/clear inputs, expire output), instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Fetch read, `i_addr`=0x100, slave acks 1 cycle after `bus_req` with 0xDEADBEEF → `bus_sel`=4'b1111, `i_ack` pulse at cycle 2, `i_rdata`=0xDEADBEEF, `stall_req` high in cycles 0–1.
- `i_req` and `d_req` both rise together, `d_we`=1, `d_sel`=4'b0011 → D granted first with `bus_we`=1 and `bus_sel`=4'b0011, then I granted in the following IDLE.
- `d_req` held continuously with `i_req`=1, MAX_D_BURST=4 → exactly 4 D grants, then 1 I grant, then D resumes.
- Assert `rst` while in BUSY_D with the slave stalling → `bus_req` falls without waiting for a clock edge, no `d_ack`; a `bus_ack` after release produces no ack.
- With the macro and TIMEOUT=8, slave never acks → `d_ack`=1, `d_rdata`=0, `bus_err`=1 on the same cycle, FSM returns to IDLE.
- Without the macro, slave acks after 300 cycles → access completes normally, `bus_err` stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the memory bus arbiter.
//   - FSM state encoding (IDLE / BUSY_I / BUSY_D / RESP)
//   - default address/data widths
//   - SEL_ALL byte-enable constant used for instruction fetches
package arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: bus cycle watchdog for mem_bus_arbiter.
// Ports:
//   clk, rst  - clock, async active-high reset
//   start     - high every cycle a bus access is outstanding (counts)
//   clear     - high when no access is outstanding (counter to 0)
//   expire    - high during the TIMEOUT-th outstanding cycle
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (start && cnt != CW'(TIMEOUT))
            cnt <= cnt + CW'(1);
    end

    // cnt holds the number of completed busy cycles, so comparing with
    // TIMEOUT-1 flags the TIMEOUT-th busy cycle itself.
    assign expire = start && !clear && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the fetch port
// (i_*) and the MEM-stage data port (d_*). Data wins unless a fetch has
// been waiting through MAX_D_BURST consecutive data grants.
// Ports:
//   clk, rst                         - clock, async active-high reset
//   i_req/i_addr -> i_ack/i_rdata    - fetch port
//   d_req/d_we/d_sel/d_addr/d_wdata -> d_ack/d_rdata - data port
//   bus_req/we/sel/addr/wdata -> bus_ack/bus_rdata   - slave bus
//   bus_err                          - watchdog abort pulse
//   stall_req                        - pipeline stall while a port waits
// Optional: define MEM_ARB_TIMEOUT_EN to enable the bus watchdog
// (TIMEOUT cycles); otherwise bus_err is always 0.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err,
    output logic              stall_req
);

    localparam int BW = $clog2(MAX_D_BURST + 1);

    logic [1:0]    state;
    logic [BW-1:0] burst_cnt;
    logic          grant_d;
    logic          grant_i;
    logic          busy;
    logic          expire;

    assign busy    = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign grant_d = d_req && (!i_req || burst_cnt < BW'(MAX_D_BURST));
    assign grant_i = !grant_d && i_req;

`ifdef MEM_ARB_TIMEOUT_EN
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .start  (busy),
        .clear  (!busy),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            // acks and bus_err are single-cycle pulses
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        bus_req   <= 1'b1;
                        bus_we    <= d_we;
                        bus_sel   <= d_sel;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        state     <= ST_BUSY_D;
                        // only data grants that bypass a waiting fetch count
                        if (i_req) begin
                            if (burst_cnt != BW'(MAX_D_BURST))
                                burst_cnt <= burst_cnt + BW'(1);
                        end else begin
                            burst_cnt <= '0;
                        end
                    end else if (grant_i) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_sel   <= SEL_ALL;
                        bus_addr  <= i_addr;
                        bus_wdata <= '0;
                        state     <= ST_BUSY_I;
                        burst_cnt <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // a real slave ack beats a watchdog expiry in the same cycle
                    if (bus_ack || expire) begin
                        bus_req <= 1'b0;
                        bus_err <= !bus_ack;
                        state   <= ST_RESP;
                        if (state == ST_BUSY_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= bus_ack ? bus_rdata : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= bus_ack ? bus_rdata : '0;
                        end
                    end
                end
                default: state <= ST_IDLE;  // RESP: ack pulse is out, return
            endcase
        end
    end

    assign stall_req = (i_req && !i_ack) || (d_req && !d_ack);

endmodule
